// File: rtl/fan_pkg.sv
// Shared constants and helpers for the fan level manager and its ramp timer.
package fan_pkg;

   localparam int unsigned LEVEL_OFF           = 0;
   localparam int unsigned DEFAULT_NUM_LEVELS  = 4;
   localparam int unsigned DEFAULT_RAMP_CYCLES = 1000;

   // Limit a level to the currently allowed maximum.
   function automatic int unsigned clamp_level(input int unsigned lvl,
                                               input int unsigned maxl);
      return (lvl > maxl) ? maxl : lvl;
   endfunction

endpackage

// File: rtl/fan_ramp_timer.sv
// Ramp pacing counter: while enabled, emits a one-cycle step every RAMP_CYCLES cycles.
module fan_ramp_timer
   import fan_pkg::*;
#(
   parameter int unsigned RAMP_CYCLES = DEFAULT_RAMP_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic step_o
);

   localparam int unsigned CW   = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(RAMP_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Combinational so the level register can step on the same edge the count expires.
   assign step_o = en_i && !clr_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = '0;
      if (!clr_i && en_i && !step_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fan_level_manager.sv
// Fan speed manager: button-driven target level with soft ramp of the applied level,
// low-battery capping and immediate battery-empty shutdown.
module fan_level_manager
   import fan_pkg::*;
#(
   parameter int unsigned NUM_LEVELS  = DEFAULT_NUM_LEVELS,
   parameter int unsigned LW          = $clog2(NUM_LEVELS),
   parameter int unsigned RAMP_CYCLES = DEFAULT_RAMP_CYCLES,
   parameter int unsigned LOW_CAP     = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          btn_up_press,
   input  logic          btn_down_press,
   input  logic          btn_off_press,
   input  logic          battery_empty,
   input  logic          battery_low,
   output logic [LW-1:0] target,
   output logic [LW-1:0] level,
   output logic          ramping
);

   logic [LW-1:0] target_q, target_d;
   logic [LW-1:0] level_q, level_d;
   logic          ramping_q, ramping_d;
   logic [LW-1:0] maxl_c;
   logic          step_c;

   assign maxl_c = battery_low ? LW'(LOW_CAP) : LW'(NUM_LEVELS - 1);

   fan_ramp_timer #(
      .RAMP_CYCLES (RAMP_CYCLES)
   ) u_ramp_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (level_q != target_q),
      .clr_i  (battery_empty),
      .step_o (step_c)
   );

   // Target priority: empty > off > up+down > up > down > low-battery clamp.
   always_comb begin
      target_d  = target_q;
      level_d   = level_q;
      ramping_d = 1'b0;

      if (battery_empty || btn_off_press) begin
         target_d = LW'(LEVEL_OFF);
      end else if (btn_up_press && btn_down_press) begin
         target_d = target_q;
      end else if (btn_up_press) begin
         target_d = (target_q >= maxl_c) ? LW'(LEVEL_OFF) : target_q + LW'(1);
      end else if (btn_down_press) begin
         target_d = (target_q == LW'(LEVEL_OFF)) ? LW'(LEVEL_OFF) : target_q - LW'(1);
      end else begin
         target_d = LW'(clamp_level(32'(target_q), 32'(maxl_c)));
      end

      // Step direction uses the registered target, so a reversal takes effect on the next step.
      if (battery_empty) begin
         level_d = LW'(LEVEL_OFF);
      end else if (step_c) begin
         level_d = (level_q < target_q) ? level_q + LW'(1) : level_q - LW'(1);
      end

      ramping_d = (level_d != target_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_q  <= '0;
         level_q   <= '0;
         ramping_q <= 1'b0;
      end else begin
         target_q  <= target_d;
         level_q   <= level_d;
         ramping_q <= ramping_d;
      end
   end

   assign target  = target_q;
   assign level   = level_q;
   assign ramping = ramping_q;

endmodule

// File: tb/tb_fan_level_manager.sv
// Directed plus random checks of fan_level_manager against a cycle-level reference model.
module tb_fan_level_manager;

   localparam int N  = 4;
   localparam int RC = 4;
   localparam int LC = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       btn_up_press = 1'b0;
   logic       btn_down_press = 1'b0;
   logic       btn_off_press = 1'b0;
   logic       battery_empty = 1'b0;
   logic       battery_low = 1'b0;
   logic [1:0] target;
   logic [1:0] level;
   logic       ramping;

   int total = 0;
   int bad   = 0;
   int m_t = 0, m_l = 0, m_c = 0;
   logic low_lvl = 1'b0;

   fan_level_manager #(
      .NUM_LEVELS  (N),
      .LW          (2),
      .RAMP_CYCLES (RC),
      .LOW_CAP     (LC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .btn_up_press   (btn_up_press),
      .btn_down_press (btn_down_press),
      .btn_off_press  (btn_off_press),
      .battery_empty  (battery_empty),
      .battery_low    (battery_low),
      .target         (target),
      .level          (level),
      .ramping        (ramping)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, compare all outputs after the edge.
   task automatic cyc(input logic up, input logic dn, input logic off, input logic emp);
      int maxl, nt, nl, nc;
      btn_up_press   = up;
      btn_down_press = dn;
      btn_off_press  = off;
      battery_empty  = emp;
      battery_low    = low_lvl;
      maxl = low_lvl ? LC : N - 1;
      nt = m_t; nl = m_l; nc = m_c;
      if (emp) begin
         nt = 0; nl = 0; nc = 0;
      end else begin
         if (off)              nt = 0;
         else if (up && dn)    nt = m_t;
         else if (up)          nt = (m_t >= maxl) ? 0 : m_t + 1;
         else if (dn)          nt = (m_t == 0) ? 0 : m_t - 1;
         else if (m_t > maxl)  nt = maxl;
         if (m_l == m_t) nc = 0;
         else if (m_c == RC - 1) begin
            nc = 0;
            nl = (m_l < m_t) ? m_l + 1 : m_l - 1;
         end else nc = m_c + 1;
      end
      @(posedge clk);
      #1;
      m_t = nt; m_l = nl; m_c = nc;
      btn_up_press = 1'b0; btn_down_press = 1'b0; btn_off_press = 1'b0; battery_empty = 1'b0;
      chk("model_target",  int'(target),  m_t);
      chk("model_level",   int'(level),   m_l);
      chk("model_ramping", int'(ramping), (m_l != m_t) ? 1 : 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int r;
      // Reset
      #1 rst_n = 1'b0;
      #2;
      chk("reset_target",  int'(target),  0);
      chk("reset_level",   int'(level),   0);
      chk("reset_ramping", int'(ramping), 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Up presses spaced 20 cycles, wrapping back to 0
      cyc(1'b1, 1'b0, 1'b0, 1'b0); chk("up1_target", int'(target), 1);
      idle(3);                     chk("up1_level_early", int'(level), 0);
      idle(1);                     chk("up1_level", int'(level), 1);
      idle(15);
      cyc(1'b1, 1'b0, 1'b0, 1'b0); chk("up2_target", int'(target), 2);
      idle(19);
      cyc(1'b1, 1'b0, 1'b0, 1'b0); chk("up3_target", int'(target), 3);
      idle(19);
      cyc(1'b1, 1'b0, 1'b0, 1'b0); chk("wrap_target", int'(target), 0);
      idle(20);                    chk("wrap_level", int'(level), 0);
      chk("wrap_ramping", int'(ramping), 0);

      // Back-to-back ups then off ramp-down
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("b2b_target", int'(target), 3);
      idle(12); chk("b2b_level", int'(level), 3); chk("b2b_ramping", int'(ramping), 0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0); chk("off_target", int'(target), 0);
      idle(3); chk("off_hold", int'(level), 3);
      idle(1); chk("off_l2", int'(level), 2);
      idle(4); chk("off_l1", int'(level), 1);
      idle(4); chk("off_l0", int'(level), 0);

      // Direction reversal mid-ramp
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle(6); chk("rev_level2", int'(level), 2);
      idle(1);
      repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("rev_target", int'(target), 1);
      idle(20); chk("rev_level", int'(level), 1); chk("rev_ramping", int'(ramping), 0);

      // Low-battery cap
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle(12); chk("low_pre_level", int'(level), 3);
      low_lvl = 1'b1;
      idle(1);  chk("low_clamp_target", int'(target), 1);
      idle(12); chk("low_level", int'(level), 1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0); chk("low_wrap_target", int'(target), 0);
      idle(8);
      low_lvl = 1'b0;
      idle(1);

      // Battery empty mid-ramp
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle(7); chk("emp_pre_level", int'(level), 2);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("emp_level", int'(level), 0); chk("emp_target", int'(target), 0);
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b1);
      chk("emp_up_target", int'(target), 0);
      idle(2);

      // Simultaneous up+down, then async reset mid-ramp
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0); chk("updown_target", int'(target), 1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle(5);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_target",  int'(target),  0);
      chk("arst_level",   int'(level),   0);
      chk("arst_ramping", int'(ramping), 0);
      m_t = 0; m_l = 0; m_c = 0;
      #1 rst_n = 1'b1;
      idle(2);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 63));
         if ($urandom_range(0, 39) == 0) low_lvl = ~low_lvl;
         cyc(r < 9 || r == 17, (r >= 9 && r < 16) || r == 17, r == 16, r == 18);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
